midi_tx_scheduler: RTL and testbench
====================================

Name: midi_tx_scheduler

Overview:
- Shares the single MIDI UART transmitter between several message sources, e.g. patch-dump engine, MIDI thru/merge and controller echo.
- Grants one source at a time using round-robin arbitration.
- Latches that source's 1–3 byte message and drives the UART byte handshake (send strobe / out_ready) byte by byte until the message is fully shifted out.
- Sits between the synth controller's message producers and the UART transmitter port.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- TIMEOUT_CYC, 4096, reg_clk cycles to wait for midi_out_ready to fall after a send strobe before declaring a stall.

Ports:
- reg_clk  input  1  system clock; all state on rising edge.
- reset_reg_N  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per source; held until ack.
- msg_data  input  24*NUM_REQ  per source {byte0,byte1,byte2}; byte0 in bits [23:16] of each slice.
- msg_len  input  2*NUM_REQ  per source byte count 0..3.
- ack  output  NUM_REQ  one-cycle pulse: message latched, source may change msg_data.
- done  output  NUM_REQ  one-cycle pulse: last byte of that source's message completed.
- midi_send_byte  output  1  one-cycle strobe to UART.
- midi_out_data  output  8  byte to UART.
- midi_out_ready  input  1  UART idle/ready, high when idle.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  3  index of the current or last granted source.
- tx_err  output  1  sticky stall flag; cleared by err_clr.
- err_clr  input  1  clears tx_err.

Behaviour:
- Reset values: ack=0, done=0, midi_send_byte=0, midi_out_data=0, busy=0, grant_id=0, tx_err=0, rr pointer=0, state IDLE. Reset mid-message abandons the message; no done is issued.
- States: IDLE, LATCH, STROBE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr pointer, with wrap-around.
  - Next edge: state LATCH, grant_id set.
- LATCH (1 cycle):
  - ack[grant] pulses.
  - Message and length latched; byte index cleared.
  - rr pointer = grant+1 mod NUM_REQ.
  - If len==0: done[grant] pulses in the same cycle and next state is IDLE. Otherwise next state is STROBE.
- STROBE (1 cycle):
  - midi_out_data = current byte; midi_send_byte=1.
  - Timeout counter cleared. Next state WAIT_LOW.
- midi_out_data holds its value from STROBE until exit of WAIT_HIGH. The UART latches it asynchronously a variable delay later.
- WAIT_LOW:
  - Waits for midi_out_ready==0.
  - If TIMEOUT_CYC cycles elapse first: tx_err set, byte treated as sent, advance as from WAIT_HIGH.
- WAIT_HIGH:
  - Waits for midi_out_ready==1 (no timeout).
  - If more bytes remain: byte index+1, next state STROBE.
  - Otherwise: done[grant] pulses, next state IDLE.
- Back-to-back: a source re-requesting right after done is not regranted while another req bit is set (fairness). A single requester is regranted from IDLE with no extra idle cycle beyond IDLE→LATCH.
- req bits changing during a message are ignored until IDLE.
- err_clr and a simultaneous new error: set wins.
- Byte index is 2 bits; len 3 sends byte0, byte1, byte2 in that order.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- When defined:
  - Register last_status (reset 0x00).
  - In LATCH, if len>=2, byte0 is in 0x80–0xEF and byte0==last_status, byte0 is skipped: transmission starts at byte1.
  - After any byte0 in 0x80–0xEF is sent, last_status = byte0.
  - Byte0 in 0xF0–0xF7 clears last_status. Byte0 in 0xF8–0xFF leaves it unchanged.
  - A timeout clears last_status.
  - done and ack timing unchanged.
- When undefined: every byte is always sent and no last_status register exists.

Test Plan:
- Single source 0 sends {0x90,0x3C,0x64}, len 3, with a UART model (ready low 5 cycles after strobe, high 40 cycles later) -> 3 strobes carrying 0x90, 0x3C, 0x64; one ack and one done[0]; busy returns low.
- req=4'b1011 held continuously -> grant order 0, 1, 3, 0, 1, 3 by grant_id; each grant sends its own bytes intact.
- len=0 on source 2 -> ack[2] and done[2] in the same LATCH cycle; no midi_send_byte.
- UART model never drops ready, TIMEOUT_CYC=16 -> tx_err=1 after 16 cycles per byte, message completes with done; err_clr pulse -> tx_err=0.
- With MIDI_RUNNING_STATUS_EN, send {0x90,0x40,0x7F} then {0x90,0x41,0x7F} -> second message emits only 0x41, 0x7F. Then {0xF8}, len 1, then {0x90,0x42,0x00} -> 0xF8, then only 0x42, 0x00.
- Assert reset_reg_N low during WAIT_HIGH of byte 2 -> all outputs return to reset values immediately; after release, the next req starts from source 0 with byte0.

Source files
------------

// File: rtl/midi_tx_scheduler.sv
// Round-robin scheduler sharing one MIDI UART transmitter between NUM_REQ message sources.
// Optional running-status byte suppression is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   reg_clk,
    input  logic                   reset_reg_N,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [24*NUM_REQ-1:0]  msg_data,
    input  logic [2*NUM_REQ-1:0]   msg_len,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   midi_send_byte,
    output logic [7:0]             midi_out_data,
    input  logic                   midi_out_ready,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   tx_err,
    input  logic                   err_clr
);

    // state     | meaning
    // IDLE      | no message in flight, arbitrating over req
    // LATCH     | ack granted source, capture its message and length
    // STROBE    | present current byte, pulse midi_send_byte
    // WAIT_LOW  | wait for UART to go busy (ready low), bounded by TIMEOUT_CYC
    // WAIT_HIGH | wait for UART to return idle, then next byte or done
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LATCH     = 3'd1,
        STROBE    = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_grant;
    logic [2:0]         r_rr;
    logic [23:0]        r_msg;
    logic [1:0]         r_len;
    logic [1:0]         r_idx;
    logic [7:0]         r_out_data;
    logic [TW-1:0]      r_tmo;
    logic               r_tx_err;

    logic [2:0]         w_pick;
    logic               w_pick_vld;
    logic [23:0]        w_sel_data;
    logic [1:0]         w_sel_len;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_skip;
    logic [1:0]         w_start;
    logic               w_adv;
    logic               w_last;
    logic               w_tmo_hit;

    function automatic logic [7:0] byte_of(input logic [23:0] m, input logic [1:0] i);
        case (i)
            2'd0:    return m[23:16];
            2'd1:    return m[15:8];
            default: return m[7:0];
        endcase
    endfunction

    // First set req bit at or above the rr pointer, wrapping; lowest offset wins.
    always_comb begin
        w_pick     = 3'd0;
        w_pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(r_rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                w_pick     = 3'(j);
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_sel_data = msg_data[24*r_grant +: 24];
    assign w_sel_len  = msg_len[2*r_grant +: 2];
    assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_last     = (r_idx == r_len - 2'd1);
    assign w_start    = w_skip ? 2'd1 : 2'd0;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_last_status;
    logic [7:0] w_b0_sent;

    assign w_skip = (w_sel_len >= 2'd2) && (w_sel_data[23:16] >= 8'h80) &&
                    (w_sel_data[23:16] <= 8'hEF) && (w_sel_data[23:16] == r_last_status);
    assign w_b0_sent = r_msg[23:16];

    // Timeout clears; otherwise a completed byte0 updates per its class.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_last_status <= 8'h00;
        end else if (w_tmo_hit) begin
            r_last_status <= 8'h00;
        end else if (w_adv && (r_idx == 2'd0)) begin
            if (w_b0_sent >= 8'h80 && w_b0_sent <= 8'hEF)
                r_last_status <= w_b0_sent;
            else if (w_b0_sent >= 8'hF0 && w_b0_sent <= 8'hF7)
                r_last_status <= 8'h00;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        ack            = '0;
        done           = '0;
        midi_send_byte = 1'b0;
        w_adv          = 1'b0;
        w_tmo_hit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) w_next = LATCH;
            end
            LATCH: begin
                ack = w_onehot;
                if (w_sel_len == 2'd0) begin
                    done   = w_onehot;
                    w_next = IDLE;
                end else begin
                    w_next = STROBE;
                end
            end
            STROBE: begin
                midi_send_byte = 1'b1;
                w_next         = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!midi_out_ready) begin
                    w_next = WAIT_HIGH;
                end else if (r_tmo == '0) begin
                    w_adv     = 1'b1;
                    w_tmo_hit = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (midi_out_ready) w_adv = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        if (w_adv) begin
            if (w_last) begin
                done   = w_onehot;
                w_next = IDLE;
            end else begin
                w_next = STROBE;
            end
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state    <= IDLE;
            r_grant    <= 3'd0;
            r_rr       <= 3'd0;
            r_msg      <= 24'd0;
            r_len      <= 2'd0;
            r_idx      <= 2'd0;
            r_out_data <= 8'd0;
            r_tmo      <= '0;
            r_tx_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_pick_vld) r_grant <= w_pick;
            if (r_state == LATCH) begin
                r_rr  <= (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
                r_msg <= w_sel_data;
                r_len <= w_sel_len;
                r_idx <= w_start;
                if (w_sel_len != 2'd0) r_out_data <= byte_of(w_sel_data, w_start);
            end
            if (r_state == STROBE)
                r_tmo <= TMO_LOAD;
            else if (r_state == WAIT_LOW && midi_out_ready && r_tmo != '0)
                r_tmo <= r_tmo - 1'b1;
            if (w_adv && !w_last) begin
                r_idx      <= r_idx + 2'd1;
                r_out_data <= byte_of(r_msg, r_idx + 2'd1);
            end
            if (w_tmo_hit)
                r_tx_err <= 1'b1;
            else if (err_clr)
                r_tx_err <= 1'b0;
        end
    end

    assign busy          = (r_state != IDLE);
    assign grant_id      = r_grant;
    assign midi_out_data = r_out_data;
    assign tx_err        = r_tx_err;

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Scoreboard bench for midi_tx_scheduler: a message-level reference model predicts grant order
// and emitted bytes; a monitor compares ack/strobe/done activity against the expected queue.
module tb_midi_tx_scheduler;
    localparam int NR  = 4;
    localparam int TMO = 16;

    logic              reg_clk;
    logic              reset_reg_N;
    logic [NR-1:0]     req;
    logic [24*NR-1:0]  msg_data;
    logic [2*NR-1:0]   msg_len;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     done;
    logic              midi_send_byte;
    logic [7:0]        midi_out_data;
    logic              midi_out_ready;
    logic              busy;
    logic [2:0]        grant_id;
    logic              tx_err;
    logic              err_clr;

    midi_tx_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
        .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .req(req), .msg_data(msg_data),
        .msg_len(msg_len), .ack(ack), .done(done), .midi_send_byte(midi_send_byte),
        .midi_out_data(midi_out_data), .midi_out_ready(midi_out_ready), .busy(busy),
        .grant_id(grant_id), .tx_err(tx_err), .err_clr(err_clr)
    );

    initial begin
        reg_clk = 1'b0;
        forever #5 reg_clk = ~reg_clk;
    end

    typedef struct {
        int              src;
        int              n;
        logic [2:0][7:0] b;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_rr = 0;
    logic [7:0]  m_last = 8'h00;
    bit          stall = 1'b0;
    bit          fixed_delay = 1'b0;
    bit          mon_en = 1'b1;

    logic [23:0] b_data [NR][4];
    logic [1:0]  b_len  [NR][4];
    int          b_cnt  [NR];
    int          b_pos  [NR];

    int          cur_n = 0;
    logic [7:0]  cur_b [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Message-level model: what bytes a message puts on the wire given the running-status history.
    function automatic exp_t model_msg(input int src, input logic [23:0] d, input logic [1:0] len);
        exp_t e;
        logic [7:0] by [3];
        int start;
        by[0] = d[23:16]; by[1] = d[15:8]; by[2] = d[7:0];
        e.src = src; e.n = 0; e.b = '0;
        start = 0;
`ifdef MIDI_RUNNING_STATUS_EN
        if (len >= 2 && by[0] >= 8'h80 && by[0] <= 8'hEF && by[0] == m_last) start = 1;
        if (len != 0) begin
            if (stall) m_last = 8'h00;
            else if (start == 0) begin
                if (by[0] >= 8'h80 && by[0] <= 8'hEF) m_last = by[0];
                else if (by[0] >= 8'hF0 && by[0] <= 8'hF7) m_last = 8'h00;
            end
        end
`endif
        for (int i = start; i < int'(len); i++) begin
            e.b[e.n] = by[i];
            e.n++;
        end
        return e;
    endfunction

    // UART: ready falls some cycles after each strobe and rises again later, unless stalled.
    initial begin
        int dl, dh;
        midi_out_ready = 1'b1;
        forever begin
            @(negedge reg_clk);
            if (midi_send_byte && !stall) begin
                dl = fixed_delay ? 5 : int'($urandom_range(1, 8));
                dh = fixed_delay ? 40 : int'($urandom_range(1, 30));
                repeat (dl) @(negedge reg_clk);
                midi_out_ready = 1'b0;
                repeat (dh) @(negedge reg_clk);
                midi_out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the expected queue on ack/done and compares bytes seen in between.
    always @(negedge reg_clk) begin
        if (mon_en && reset_reg_N) begin
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    chk("ack_src", 32'(ack), 32'(1) << sb[0].src);
                    chk("grant_id", 32'(grant_id), 32'(sb[0].src));
                end
                cur_n = 0;
            end
            if (midi_send_byte) begin
                if (cur_n < 4) cur_b[cur_n] = midi_out_data;
                cur_n++;
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    chk("done_src", 32'(done), 32'(1) << sb[0].src);
                    chk("byte_count", 32'(cur_n), 32'(sb[0].n));
                    for (int i = 0; i < sb[0].n && i < cur_n; i++)
                        chk("byte_value", 32'(cur_b[i]), 32'(sb[0].b[i]));
                    void'(sb.pop_front());
                end
                cur_n = 0;
            end
        end
    end

    task automatic run_batch(input int budget);
        int pend [NR];
        int k [NR];
        int s, cyc;
        bit any;
        logic [NR-1:0] a;
        for (int i = 0; i < NR; i++) begin pend[i] = b_cnt[i]; k[i] = 0; end
        do begin
            any = 1'b0;
            for (int i = 0; i < NR; i++) if (pend[i] > 0) any = 1'b1;
            if (any) begin
                s = -1;
                for (int i = 0; i < NR && s < 0; i++)
                    if (pend[(m_rr + i) % NR] > 0) s = (m_rr + i) % NR;
                sb.push_back(model_msg(s, b_data[s][k[s]], b_len[s][k[s]]));
                k[s]++; pend[s]--;
                m_rr = (s + 1) % NR;
            end
        end while (any);
        for (int i = 0; i < NR; i++) begin
            b_pos[i] = 0;
            if (b_cnt[i] > 0) begin
                msg_data[24*i +: 24] = b_data[i][0];
                msg_len[2*i +: 2]    = b_len[i][0];
                req[i] = 1'b1;
            end
        end
        cyc = 0;
        while ((sb.size() != 0 || busy || req != '0) && cyc < budget) begin
            @(negedge reg_clk);
            cyc++;
            a = ack;
            if (a != '0) begin
                @(posedge reg_clk);
                #1;
                for (int i = 0; i < NR; i++) if (a[i]) begin
                    b_pos[i]++;
                    if (b_pos[i] < b_cnt[i]) begin
                        msg_data[24*i +: 24] = b_data[i][b_pos[i]];
                        msg_len[2*i +: 2]    = b_len[i][b_pos[i]];
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
        end
        chk("batch_completes", 32'(cyc < budget), 32'd1);
        if (cyc >= budget) begin
            sb.delete();
            req = '0;
        end
        repeat (2) @(negedge reg_clk);
    endtask

    task automatic clear_batch();
        for (int i = 0; i < NR; i++) b_cnt[i] = 0;
    endtask

    task automatic add_msg(input int s, input logic [23:0] d, input logic [1:0] len);
        b_data[s][b_cnt[s]] = d;
        b_len[s][b_cnt[s]]  = len;
        b_cnt[s]++;
    endtask

    task automatic add_rand_msg(input int s);
        logic [7:0] b0;
        logic [1:0] len;
        case ($urandom_range(0, 3))
            0: b0 = 8'h90;
            1: b0 = 8'hB0;
            2: b0 = 8'hF8;
            default: b0 = 8'($urandom_range(0, 255));
        endcase
        len = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        add_msg(s, {b0, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127))}, len);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_send"}, 32'(midi_send_byte), 32'd0);
        chk({tag, "_data"}, 32'(midi_out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'd0);
        chk({tag, "_txerr"}, 32'(tx_err), 32'd0);
    endtask

    initial begin
        int c, nstb;
        reset_reg_N = 1'b0;
        req = '0; msg_data = '0; msg_len = '0; err_clr = 1'b0;
        clear_batch();
        repeat (3) @(negedge reg_clk);
        check_reset_outputs("reset");
        reset_reg_N = 1'b1;
        repeat (2) @(negedge reg_clk);

        // single source, fixed UART timing
        fixed_delay = 1'b1;
        clear_batch();
        add_msg(0, 24'h903C64, 2'd3);
        run_batch(2000);
        chk("busy_low_after_msg", 32'(busy), 32'd0);
        fixed_delay = 1'b0;

        // three sources held, two messages each
        clear_batch();
        for (int r = 0; r < 2; r++) begin
            add_msg(0, 24'h90_10_20 + 24'(r), 2'd3);
            add_msg(1, 24'hB0_07_40 + 24'(r), 2'd3);
            add_msg(3, 24'hC0_05_00, 2'd2);
        end
        run_batch(6000);

        // zero-length message on source 2
        clear_batch();
        add_msg(2, 24'h123456, 2'd0);
        run_batch(200);

        // UART never drops ready: every byte times out
        stall = 1'b1;
        clear_batch();
        add_msg(1, 24'h80_11_22, 2'd2);
        fork
            run_batch(500);
            begin
                c = 0;
                while (!midi_send_byte && c < 100) begin @(negedge reg_clk); c++; end
                c = 0;
                do begin @(negedge reg_clk); c++; end while (!tx_err && c < 100);
                chk("timeout_cycles", 32'(c), 32'(TMO + 1));
            end
        join
        chk("tx_err_set", 32'(tx_err), 32'd1);
        stall = 1'b0;
        @(negedge reg_clk); err_clr = 1'b1;
        @(negedge reg_clk); err_clr = 1'b0;
        chk("tx_err_cleared", 32'(tx_err), 32'd0);

        // running-status sequence from one source
        clear_batch();
        add_msg(0, 24'h90407F, 2'd3);
        add_msg(0, 24'h90417F, 2'd3);
        add_msg(0, 24'hF80000, 2'd1);
        add_msg(0, 24'h904200, 2'd3);
        run_batch(6000);

        // random batches
        for (int r = 0; r < 6; r++) begin
            clear_batch();
            for (int s = 0; s < NR; s++) begin
                int nm;
                nm = int'($urandom_range(0, 2));
                for (int j = 0; j < nm; j++) add_rand_msg(s);
            end
            if (b_cnt[0] + b_cnt[1] + b_cnt[2] + b_cnt[3] == 0) add_rand_msg(int'($urandom_range(0, NR-1)));
            run_batch(12000);
        end
        chk("tx_err_clean", 32'(tx_err), 32'd0);

        // reset during WAIT_HIGH of byte 2
        mon_en = 1'b0;
        msg_data[23:0] = 24'h901122; msg_len[1:0] = 2'd3; req[0] = 1'b1;
        c = 0;
        while (ack[0] !== 1'b1 && c < 100) begin @(negedge reg_clk); c++; end
        @(posedge reg_clk); #1; req[0] = 1'b0;
        nstb = 0; c = 0;
        while (nstb < 2 && c < 500) begin
            @(negedge reg_clk); c++;
            if (midi_send_byte) nstb++;
        end
        c = 0;
        while (midi_out_ready && c < 100) begin @(negedge reg_clk); c++; end
        chk("reached_wait_high", 32'(midi_out_ready), 32'd0);
        reset_reg_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        c = 0;
        while (!midi_out_ready && c < 200) begin @(negedge reg_clk); c++; end
        repeat (2) @(negedge reg_clk);
        reset_reg_N = 1'b1;
        m_rr = 0; m_last = 8'h00; cur_n = 0;
        mon_en = 1'b1;
        clear_batch();
        add_msg(2, 24'h903344, 2'd3);
        add_msg(0, 24'h901122, 2'd3);
        run_batch(4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
